// File: rtl/sc_fir_pkg.sv
// Shared constants and types for the stochastic-computing FIR front end:
// default geometry, LFSR defaults and the sequencer state encoding.
package sc_fir_pkg;

  localparam int unsigned SC_N     = 11;
  localparam int unsigned SC_ORDER = 9;
  localparam int unsigned POW2N_M1 = (1 << SC_N) - 1;

  // x^11 + x^9 + 1: feedback from bits 10 and 8, maximal length 2047.
  localparam logic [SC_N-1:0] LFSR_TAPS_DEFAULT = 11'h500;
  localparam logic [SC_N-1:0] LFSR_SEED_DEFAULT = 11'h001;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    RUN   = 2'd2
  } seq_state_e;

endpackage

// File: rtl/sc_lfsr.sv
// W-bit Fibonacci LFSR: shifts left, new LSB is the parity of the tapped bits.
// load has priority over enable; the register resets to RST_VAL.
module sc_lfsr #(
  parameter int unsigned    W       = 11,
  parameter logic [W-1:0]   RST_VAL = {{(W-1){1'b0}}, 1'b1}
) (
  input  logic         clock,
  input  logic         reset_n,
  input  logic         load,
  input  logic         enable,
  input  logic [W-1:0] seed,
  input  logic [W-1:0] taps,
  output logic [W-1:0] q
);

  logic [W-1:0] state_q, state_d;

  always_comb begin
    state_d = state_q;
    if (load) begin
      state_d = seed;
    end else if (enable) begin
      state_d = {state_q[W-2:0], ^(state_q & taps)};
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= RST_VAL;
    end else begin
      state_q <= state_d;
    end
  end

  assign q = state_q;

endmodule

// File: rtl/sc_fir_sequencer.sv
// Input stage and window sequencer for the SC FIR: accepts samples into the
// tap delay line, runs one 2^N-cycle HWA window per sample, captures the count.
module sc_fir_sequencer
  import sc_fir_pkg::*;
#(
  parameter int unsigned  N         = SC_N,
  parameter int unsigned  ORDER     = SC_ORDER,
  parameter logic [N-1:0] LFSR_TAPS = LFSR_TAPS_DEFAULT,
  parameter logic [N-1:0] LFSR_SEED = LFSR_SEED_DEFAULT
) (
  input  logic                 clock,
  input  logic                 reset_n,
  input  logic [N:0]           sample_in,
  input  logic                 sample_valid,
  output logic                 sample_ready,
  output logic [ORDER:0][N:0]  taps_out,
  output logic                 start,
  output logic [N-1:0]         sel_bits,
  output logic [N-1:0]         R_y,
  input  logic [N:0]           hwa_out,
  input  logic                 hwa_done,
  output logic [N:0]           result,
  output logic                 result_valid
);

  // Reset asserts asynchronously but is released on a clock edge two flops later.
  logic rst_meta_q, rst_int_n_q;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      rst_meta_q  <= 1'b0;
      rst_int_n_q <= 1'b0;
    end else begin
      rst_meta_q  <= 1'b1;
      rst_int_n_q <= rst_meta_q;
    end
  end

  seq_state_e          state_q, state_d;
  logic [N-1:0]        sel_q, sel_d;
  logic [ORDER:0][N:0] taps_q, taps_d;
  logic [N:0]          result_q, result_d;
  logic                result_valid_q, result_valid_d;
  logic                seq_err_q, seq_err_d;

  logic sel_last;
  logic hwa_done_exp;
  logic lfsr_load;
  logic lfsr_en;

  assign sel_last     = (sel_q == {N{1'b1}});
  assign hwa_done_exp = (state_q == RUN) && sel_last;

  // NOTE: every signal written here gets a default first, so no path can
  // leave one unassigned and infer a latch.
  always_comb begin
    state_d        = state_q;
    sel_d          = sel_q;
    taps_d         = taps_q;
    result_d       = result_q;
    result_valid_d = 1'b0;
    seq_err_d      = seq_err_q | (hwa_done != hwa_done_exp);
    sample_ready   = 1'b0;
    start          = 1'b0;
    lfsr_load      = 1'b0;
    lfsr_en        = 1'b0;

    unique case (state_q)
      IDLE: begin
        sample_ready = 1'b1;
        if (sample_valid) begin
          taps_d  = {taps_q[ORDER-1:0], sample_in};
          state_d = START;
        end
      end
      START: begin
        start     = 1'b1;
        lfsr_load = 1'b1;
        sel_d     = '0;
        state_d   = RUN;
      end
      RUN: begin
        lfsr_en = 1'b1;
        if (sel_last) begin
          // The counter stops at its maximum and is cleared on the way out.
          result_d       = hwa_out;
          result_valid_d = 1'b1;
          sel_d          = '0;
          state_d        = IDLE;
        end else begin
          sel_d = sel_q + 1'b1;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // pre-edge values regardless of statement order.
  // NOTE: the delay line is plain flops, not a RAM, so it is reset with the
  // rest of the state; a reset must leave every tap at zero.
  always_ff @(posedge clock or negedge rst_int_n_q) begin
    if (!rst_int_n_q) begin
      state_q        <= IDLE;
      sel_q          <= '0;
      taps_q         <= '0;
      result_q       <= '0;
      result_valid_q <= 1'b0;
      seq_err_q      <= 1'b0;
    end else begin
      state_q        <= state_d;
      sel_q          <= sel_d;
      taps_q         <= taps_d;
      result_q       <= result_d;
      result_valid_q <= result_valid_d;
      seq_err_q      <= seq_err_d;
    end
  end

  sc_lfsr #(
    .W       (N),
    .RST_VAL (LFSR_SEED)
  ) u_lfsr (
    .clock   (clock),
    .reset_n (rst_int_n_q),
    .load    (lfsr_load),
    .enable  (lfsr_en),
    .seed    (LFSR_SEED),
    .taps    (LFSR_TAPS),
    .q       (R_y)
  );

  assign taps_out     = taps_q;
  assign sel_bits     = sel_q;
  assign result       = result_q;
  assign result_valid = result_valid_q;

  // hwa_done disagreeing with the sequencer's own view of the window is fatal in simulation.
  seq_err_chk: assert property (@(posedge clock) disable iff (!rst_int_n_q) !seq_err_q);

endmodule

// File: tb/tb_sc_fir_sequencer.sv
// Self-checking bench for sc_fir_sequencer: HWA stub, window timing checks,
// LFSR reference model and a result scoreboard.
module tb_sc_fir_sequencer;
  import sc_fir_pkg::*;

  localparam int          WIN      = 2048;
  localparam logic [10:0] SEL_LAST = 11'h7FF;
  localparam logic [11:0] SMP  [9] = '{12'h001, 12'h7FF, 12'h800, 12'hFFF, 12'h123,
                                       12'h456, 12'h89A, 12'hCDE, 12'h3C3};
  localparam logic [11:0] CAPS [9] = '{12'h011, 12'h022, 12'hFFF, 12'h000, 12'h5A5,
                                       12'hA5A, 12'h7FF, 12'h800, 12'h9E1};

  logic                clock = 1'b0;
  logic                reset_n;
  logic [11:0]         sample_in;
  logic                sample_valid;
  logic                sample_ready;
  logic [9:0][11:0]    taps_out;
  logic                start;
  logic [10:0]         sel_bits;
  logic [10:0]         R_y;
  logic [11:0]         hwa_out;
  logic                hwa_done;
  logic [11:0]         result;
  logic                result_valid;

  logic [11:0]         win_cap;
  logic [9:0][11:0]    m_taps;
  logic [11:0]         exp_q [$];
  logic [11:0]         sb_front;
  int                  n_tests = 0;
  int                  n_fail  = 0;

  always #5 clock = ~clock;

  // HWA stub: the count only carries the window's value on its last cycle.
  assign hwa_done = (sel_bits == SEL_LAST);
  assign hwa_out  = hwa_done ? win_cap : 12'h555;

  sc_fir_sequencer dut (
    .clock        (clock),
    .reset_n      (reset_n),
    .sample_in    (sample_in),
    .sample_valid (sample_valid),
    .sample_ready (sample_ready),
    .taps_out     (taps_out),
    .start        (start),
    .sel_bits     (sel_bits),
    .R_y          (R_y),
    .hwa_out      (hwa_out),
    .hwa_done     (hwa_done),
    .result       (result),
    .result_valid (result_valid)
  );

  task automatic check(input string tag, input logic [127:0] act, input logic [127:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  function automatic logic [10:0] lfsr_next(input logic [10:0] s);
    return {s[9:0], s[10] ^ s[8]};
  endfunction

  task automatic check_reset_state();
    check("rst_sample_ready", sample_ready, 1'b1);
    check("rst_taps", taps_out, '0);
    check("rst_start", start, 1'b0);
    check("rst_sel_bits", sel_bits, '0);
    check("rst_R_y", R_y, 11'h001);
    check("rst_result", result, '0);
    check("rst_result_valid", result_valid, 1'b0);
  endtask

  // Entered just before an accept edge (IDLE, sample_valid high). Checks the
  // whole window cycle by cycle; with hold set, the next sample is held on
  // sample_in throughout and gets accepted on the result_valid cycle.
  task automatic run_window(input logic [11:0] cap, input bit hold, input logic [11:0] next_s);
    logic [10:0] lfsr_m;
    check("ready_at_accept", sample_ready, 1'b1);
    exp_q.push_back(cap);
    win_cap = cap;
    m_taps  = {m_taps[8:0], sample_in};
    lfsr_m  = 11'h001;
    for (int k = 1; k <= WIN + 2; k++) begin
      @(negedge clock);
      check("start", start, k == 1);
      check("sample_ready", sample_ready, k == WIN + 2);
      check("result_valid", result_valid, k == WIN + 2);
      check("taps_stable", taps_out, m_taps);
      if (k <= WIN + 1) check("sel_bits", sel_bits, (k < 2) ? 0 : k - 2);
      if (k >= 2 && k <= WIN + 1) begin
        check("R_y", R_y, lfsr_m);
        lfsr_m = lfsr_next(lfsr_m);
      end
      if (k == WIN + 1) check("R_y_period", R_y, 11'h001);
      if (k == 1) begin
        if (hold) sample_in = next_s;
        else      sample_valid = 1'b0;
      end
    end
  endtask

  // Scoreboard: every result_valid must match the oldest outstanding expectation.
  always @(negedge clock) begin
    if (reset_n && result_valid) begin
      if (exp_q.size() == 0) begin
        check("unexpected_result_valid", 1'b1, 1'b0);
      end else begin
        sb_front = exp_q.pop_front();
        check("result", result, sb_front);
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bit found;
    int rv_seen;

    reset_n      = 1'b0;
    sample_valid = 1'b0;
    sample_in    = '0;
    win_cap      = '0;
    m_taps       = '0;
    repeat (3) @(negedge clock);
    check_reset_state();
    reset_n = 1'b1;
    repeat (4) @(negedge clock);
    check("ready_after_release", sample_ready, 1'b1);

    // Single sample with full timing checks.
    sample_in    = 12'h400;
    sample_valid = 1'b1;
    run_window(12'hABC, 1'b0, 12'h000);
    check("single_taps0", taps_out[0], 12'h400);
    repeat (3) @(negedge clock);

    // Nine more samples, back to back, with sample_valid held through each RUN.
    sample_in    = SMP[0];
    sample_valid = 1'b1;
    for (int i = 0; i < 9; i++) begin
      run_window(CAPS[i], i < 8, SMP[(i < 8) ? i + 1 : i]);
    end
    check("taps9_first_sample", taps_out[9], 12'h400);
    check("taps0_last_sample", taps_out[0], 12'h3C3);
    repeat (2) @(negedge clock);

    // Abort a window with reset at sel_bits == 1000; nothing may be reported.
    check("ready_pre_abort", sample_ready, 1'b1);
    sample_in    = 12'h5A5;
    sample_valid = 1'b1;
    win_cap      = 12'h0F0;
    @(negedge clock);
    sample_valid = 1'b0;
    check("abort_start", start, 1'b1);
    found = 1'b0;
    for (int c = 0; c < 3000 && !found; c++) begin
      @(negedge clock);
      if (sel_bits == 11'd1000) found = 1'b1;
    end
    check("abort_reached_sel1000", found, 1'b1);
    reset_n = 1'b0;
    #1;
    check_reset_state();
    m_taps = '0;
    repeat (3) @(negedge clock);
    reset_n = 1'b1;
    rv_seen = 0;
    for (int c = 0; c < 1100; c++) begin
      @(negedge clock);
      if (result_valid) rv_seen++;
    end
    check("abort_no_result_valid", rv_seen, 0);
    check("abort_taps_cleared", taps_out, '0);
    check("abort_result_cleared", result, '0);

    // Fresh window after the abort restarts the LFSR from the seed.
    sample_in    = 12'h7FF;
    sample_valid = 1'b1;
    run_window(12'h3C5, 1'b0, 12'h000);
    check("post_abort_taps0", taps_out[0], 12'h7FF);
    check("post_abort_taps1", taps_out[1], 12'h000);
    repeat (2) @(negedge clock);

    check("scoreboard_drained", exp_q.size(), 0);
    check("seq_err", dut.seq_err_q, 1'b0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
